// File: rtl/seq_scan_sched.sv
// seq_scan_sched: round-robin scheduler feeding a shared serial "101" detector.
// Ports: clk/rst (async, active-high); req/data per requester in; gnt one-hot grant pulse;
//        busy, bit_out, match (detector in S3), done pulse with done_id / match_cnt results.
// Latency: req sampled at edge k -> gnt cycle k+1, SHIFT k+2..k+1+DATA_W, done k+2+DATA_W.

module seq_scan_sched #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATA_W-1:0]   data,
  output logic [NREQ-1:0]          gnt,
  output logic                     busy,
  output logic                     bit_out,
  output logic                     match,
  output logic                     done,
  output logic [2:0]               done_id,
  output logic [3:0]               match_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, REPORT} state_t;
  typedef enum logic [1:0] {S0, S1, S2, S3} det_t;

  state_t            state;
  det_t              det;
  det_t              det_nxt;
  logic [2:0]        last_grant;
  logic [2:0]        sel;
  logic [2:0]        pick;
  logic              found;
  logic [DATA_W-1:0] sreg;
  logic [3:0]        bit_cnt;
  logic [3:0]        acc;
  logic [3:0]        acc_nxt;
  logic              sbit;

  // Bit currently presented to the detector is the shift register MSB.
  assign sbit    = sreg[DATA_W-1];
  assign bit_out = (state == SHIFT) & sbit;
  assign busy    = (state != IDLE);
  assign match   = (det == S3);

  // Round-robin pick: scan starting one past the last granted requester.
  always_comb begin
    int idx;
    idx   = 0;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(last_grant) + i) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx[2:0];
      end
    end
  end

  // Moore "101" detector next state; S3 falls back to S2 on 0 so overlaps count.
  always_comb begin
    det_nxt = det;
    case (det)
      S0:      det_nxt = sbit ? S1 : S0;
      S1:      det_nxt = sbit ? S1 : S2;
      S2:      det_nxt = sbit ? S3 : S0;
      S3:      det_nxt = sbit ? S1 : S2;
      default: det_nxt = S0;
    endcase
  end

  assign acc_nxt = acc + ((det_nxt == S3) ? 4'd1 : 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      det        <= S0;
      gnt        <= '0;
      done       <= 1'b0;
      done_id    <= '0;
      match_cnt  <= '0;
      last_grant <= 3'(NREQ - 1);
      sel        <= '0;
      sreg       <= '0;
      bit_cnt    <= '0;
      acc        <= '0;
    end else begin
      gnt  <= '0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            sel   <= pick;
            // Grant is registered so it is high for exactly the LOAD cycle.
            gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
            state <= LOAD;
          end
        end
        LOAD: begin
          sreg       <= data[int'(sel)*DATA_W +: DATA_W];
          last_grant <= sel;
          bit_cnt    <= '0;
          acc        <= '0;
          det        <= S0;  // fresh detector per job, no cross-job matches
          state      <= SHIFT;
        end
        SHIFT: begin
          sreg    <= {sreg[DATA_W-2:0], 1'b0};
          det     <= det_nxt;
          acc     <= acc_nxt;
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'(DATA_W - 1)) begin
            // acc_nxt folds in a detection on the final bit.
            state     <= REPORT;
            done      <= 1'b1;
            done_id   <= sel;
            match_cnt <= acc_nxt;
          end
        end
        REPORT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_scan_sched.sv
// Directed bench for seq_scan_sched (NREQ=4, DATA_W=8) with hand-computed expectations.
// Outputs are sampled on the falling edge; inputs are driven on the falling edge.
// One checking task counts every comparison and reports mismatches.

module tb_seq_scan_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] data = '0;
  logic [3:0]  gnt;
  logic        busy, bit_out, match, done;
  logic [2:0]  done_id;
  logic [3:0]  match_cnt;

  int checks = 0;
  int failures = 0;
  int tick = 0;

  // Per-job observations filled in by run_job.
  int cyc, g1, mmask, bmask, gor, mid_id, mid_cnt, t_prev, any_done, any_gnt;

  seq_scan_sched #(.NREQ(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .gnt(gnt), .busy(busy),
    .bit_out(bit_out), .match(match), .done(done), .done_id(done_id),
    .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tick <= tick + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Starts in IDLE at a falling edge with req = r; returns at the done cycle (or timeout).
  // cyc counts cycles after the sampling edge; done is expected at cyc==10.
  task automatic run_job(input logic [3:0] r, input bit hold, input logic [3:0] pmask);
    cyc = 0; g1 = 0; mmask = 0; bmask = 0; gor = 0; mid_id = -1; mid_cnt = -1;
    req = r;
    while (!done && cyc < 30) begin
      step();
      cyc++;
      gor |= int'(gnt);
      if (cyc == 1) begin
        g1 = int'(gnt);
        if (!hold) req = '0;
      end
      if (cyc == 4 && !hold && pmask != 0) req = pmask;
      if (cyc == 5) begin
        mid_id  = int'(done_id);
        mid_cnt = int'(match_cnt);
        if (!hold) req = '0;
      end
      if (cyc >= 2 && cyc <= 10 && match) mmask |= (1 << cyc);
      if (cyc >= 2 && cyc <= 9) bmask = (bmask << 1) | int'(bit_out);
    end
  endtask

  initial begin
    data = {8'h00, 8'hFF, 8'hA5, 8'hAA};
    #2;
    // Asynchronous reset values before any clock edge.
    check_eq("rst_gnt", int'(gnt), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_bit_out", int'(bit_out), 0);
    check_eq("rst_match", int'(match), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_done_id", int'(done_id), 0);
    check_eq("rst_match_cnt", int'(match_cnt), 0);
    @(negedge clk);
    do_reset();

    // Job on requester 0, data AA: three overlapping detections.
    run_job(4'b0001, 1'b0, 4'b0);
    check_eq("aa_gnt", g1, 1);
    check_eq("aa_latency", cyc, 10);
    check_eq("aa_done_id", int'(done_id), 0);
    check_eq("aa_cnt", int'(match_cnt), 3);
    check_eq("aa_bits", bmask, 'hAA);
    check_eq("aa_match_cycles", mmask, 'h2A0);
    step();
    check_eq("aa_idle_busy", int'(busy), 0);
    check_eq("aa_idle_done", int'(done), 0);

    // Requester 1, data A5: matches after bits 3 and 8.
    run_job(4'b0010, 1'b0, 4'b0);
    check_eq("a5_gnt", g1, 2);
    check_eq("a5_latency", cyc, 10);
    check_eq("a5_done_id", int'(done_id), 1);
    check_eq("a5_cnt", int'(match_cnt), 2);
    check_eq("a5_match_cycles", mmask, 'h420);
    step();

    // All ones and all zeros never form "101".
    run_job(4'b0100, 1'b0, 4'b0);
    check_eq("ff_done_id", int'(done_id), 2);
    check_eq("ff_cnt", int'(match_cnt), 0);
    step();
    run_job(4'b1000, 1'b0, 4'b0);
    check_eq("00_done_id", int'(done_id), 3);
    check_eq("00_cnt", int'(match_cnt), 0);
    step();

    // Job A ends with "10" (detector in S2); job B begins with 1: no cross-job hit.
    data = {8'h00, 8'hFF, 8'h80, 8'h02};
    run_job(4'b0001, 1'b0, 4'b0);
    check_eq("xa_cnt", int'(match_cnt), 0);
    step();
    run_job(4'b0010, 1'b0, 4'b0);
    check_eq("xb_done_id", int'(done_id), 1);
    check_eq("xb_cnt", int'(match_cnt), 0);
    check_eq("xb_match_cycles", mmask, 0);
    step();

    // Reset during the 4th SHIFT cycle aborts the job with no done pulse.
    data = {8'hAA, 8'hA5, 8'hFF, 8'hAA};
    req = 4'b1000;
    step();
    check_eq("ab_gnt", int'(gnt), 8);
    req = '0;
    repeat (4) step();
    check_eq("ab_busy_before", int'(busy), 1);
    rst = 1'b1;
    #1;
    check_eq("ab_outputs_zero", int'({gnt, busy, bit_out, match, done, done_id, match_cnt}), 0);
    any_done = 0;
    repeat (2) begin
      step();
      any_done |= int'(done);
    end
    rst = 1'b0;
    repeat (3) begin
      step();
      any_done |= int'(done);
    end
    check_eq("ab_no_done", any_done, 0);
    run_job(4'b0100, 1'b0, 4'b0);
    check_eq("ab_next_gnt", g1, 4);
    check_eq("ab_next_latency", cyc, 10);
    check_eq("ab_next_id", int'(done_id), 2);
    check_eq("ab_next_cnt", int'(match_cnt), 2);
    step();

    // Short req[1] pulse while busy is lost; results hold between dones.
    data = {8'h00, 8'hA5, 8'hAA, 8'hFF};
    run_job(4'b0001, 1'b0, 4'b0010);
    check_eq("pl_grants_seen", gor, 1);
    check_eq("pl_mid_id_hold", mid_id, 2);
    check_eq("pl_mid_cnt_hold", mid_cnt, 2);
    check_eq("pl_done_id", int'(done_id), 0);
    check_eq("pl_cnt", int'(match_cnt), 0);
    any_done = 0;
    any_gnt = 0;
    repeat (12) begin
      step();
      any_done |= int'(done);
      any_gnt |= int'(gnt);
    end
    check_eq("pl_no_more_done", any_done, 0);
    check_eq("pl_no_more_gnt", any_gnt, 0);
    check_eq("pl_id_held", int'(done_id), 0);
    check_eq("pl_cnt_held", int'(match_cnt), 0);

    // All requesters held after reset: grant order 0,1,2,3,0 with 11-cycle done spacing.
    data = {8'h00, 8'hFF, 8'hA5, 8'hAA};
    do_reset();
    t_prev = -1;
    for (int j = 0; j < 5; j++) begin
      int exp_cnt;
      case (j % 4)
        0: exp_cnt = 3;
        1: exp_cnt = 2;
        default: exp_cnt = 0;
      endcase
      run_job(4'b1111, 1'b1, 4'b0);
      check_eq($sformatf("rr%0d_gnt", j), g1, 1 << (j % 4));
      check_eq($sformatf("rr%0d_id", j), int'(done_id), j % 4);
      check_eq($sformatf("rr%0d_cnt", j), int'(match_cnt), exp_cnt);
      if (j > 0) check_eq($sformatf("rr%0d_spacing", j), tick - t_prev, 11);
      t_prev = tick;
      if (j == 4) req = '0;
      step();
      check_eq($sformatf("rr%0d_idle_busy", j), int'(busy), 0);
    end
    step();
    check_eq("rr_end_busy", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_scan_sched.md
SEQ_SCAN_SCHED -- requirements
Module: seq_scan_sched

Interface
REQ-001 Parameter: NREQ, default 4, number of requesters sharing the detector (2..8).
REQ-002 Parameter: DATA_W, default 8, bits per job word (2..15).
REQ-003 Reset is rst, asynchronous, active-high; clock is clk; all state changes occur on the rising edge of clk.
REQ-004 clk  input  1  system clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 req  input  NREQ  per-requester job request; level-sensitive, held until granted.
REQ-007 data  input  NREQ*DATA_W  per-requester job word; slice i is bits [i*DATA_W +: DATA_W].
REQ-008 gnt  output  NREQ  one-hot grant pulse, one cycle, in the LOAD state.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 bit_out  output  1  serial bit presented to the detector in the current SHIFT cycle.
REQ-011 match  output  1  Moore detector output; high while the detector is in state S3.
REQ-012 done  output  1  one-cycle pulse in the REPORT state.
REQ-013 done_id  output  3  index of the requester whose job completed; valid with done and held until the next done.
REQ-014 match_cnt  output  4  number of "101" detections in the completed job; valid with done and held until the next done.

Function
REQ-015 The controller FSM SHALL have states IDLE, LOAD, SHIFT and REPORT.
REQ-016 In IDLE with any req bit high, the FSM SHALL select a requester round-robin, starting at (last_grant+1) mod NREQ, and go to LOAD; with req all zero it SHALL stay in IDLE.
REQ-017 In LOAD (one cycle), gnt SHALL be asserted one-hot for the selected requester, its data slice SHALL be captured into the shift register, last_grant SHALL be updated, the bit counter and match_cnt accumulator SHALL be cleared, and the detector SHALL be forced to S0.
REQ-018 In SHIFT (exactly DATA_W cycles), bit_out SHALL equal the current MSB of the shift register, which SHALL shift left by one each cycle.
REQ-019 The detector SHALL be a 4-state Moore FSM: S0: 1->S1, 0->S0; S1: 1->S1, 0->S2; S2: 1->S3, 0->S0; S3: 1->S1, 0->S2. It SHALL advance only in SHIFT cycles and hold in all other states.
REQ-020 match SHALL be high when the detector is in S3, i.e. one cycle after the final 1 of a "101" is presented on bit_out. Overlapping detections SHALL count ("10101" = 2).
REQ-021 The accumulator SHALL increment on each SHIFT edge whose detector next-state is S3, including the edge of the last bit.
REQ-022 After the DATA_W-th SHIFT cycle, the FSM SHALL enter REPORT for one cycle: done=1, and done_id and match_cnt SHALL be loaded, then return to IDLE.
REQ-023 Latency SHALL be fixed: req sampled in IDLE at edge k gives gnt in cycle k+1, SHIFT in cycles k+2..k+1+DATA_W, and done in cycle k+2+DATA_W.
REQ-024 req changes outside IDLE SHALL be ignored; a req dropped before its grant SHALL be lost without side effects; data SHALL be sampled only in LOAD.
REQ-025 A requester holding req high after its grant SHALL be treated as a new job and arbitrated normally against the others.
REQ-026 The detector SHALL be reset per job, so no detection spans two jobs.

Reset
REQ-027 On rst, the block SHALL enter IDLE with the detector at S0 and gnt=0, busy=0, bit_out=0, match=0, done=0, done_id=0 and match_cnt=0.
REQ-028 On rst, last_grant SHALL be set to NREQ-1, so that requester 0 has the first priority.
REQ-029 rst asserted mid-job SHALL abort the job immediately with no done pulse; the aborted requester SHALL get no credit and SHALL re-arbitrate after reset.

Verification
REQ-030 With DATA_W=8, a single req[0] and data 8'hAA: gnt=0001 for one cycle; done 10 cycles after req is sampled; match_cnt=3; done_id=0.
REQ-031 data 8'hA5: match pulses after bits 3 and 8, and match_cnt=2; data 8'hFF or 8'h00: match_cnt=0.
REQ-032 req=1111 held continuously after reset: grant order 0,1,2,3,0; done spacing 11 cycles; busy low for exactly 1 cycle between jobs.
REQ-033 Job A ends in S2 with bits ...10, then job B starts with bit 1: job B match_cnt does not include a cross-job detection.
REQ-034 rst pulsed during the 4th SHIFT cycle: all outputs 0 asynchronously and no done pulse; the next job (req[2] only) completes normally with correct match_cnt.
REQ-035 req[1] pulsed for 1 cycle while busy, then dropped: no gnt to requester 1; done_id and match_cnt hold their previous values.
